stupidrv_mem_arbiter: RTL

// Shares one single-ported word memory between the stupidrv instruction fetch

---
 rtl/stupidrv_mem_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/stupidrv_mem_arbiter.sv
// stupidrv_mem_arbiter
//
// Lets the stupidrv instruction fetch port and data port share one single-ported
// word memory. Within a request set (the core holds its requests while stall=1),
// the data access goes first and the fetch second, so a fetch observes a store
// made in the same set. Data requests to OUT_ADDR go to a write-only output
// register. Any other out-of-range data access raises an error pulse.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   imem_addr/imem_data fetch byte address / registered fetch word
//   dmem_*              data request (wstrb=0 is a read) / registered read data
//   stall               core holds all requests while high
//   mem_*               memory request; handshake = mem_valid & mem_ready
//   out_valid/out_data  one-cycle pulse on an output-register write, with
//                       unstrobed bytes zeroed
//   err_valid/err_addr  one-cycle pulse on an out-of-range access
//   stall_count         saturating count of stall cycles since reset

module stupidrv_mem_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] OUT_ADDR       = 32'h0200_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               imem_addr,
  output logic [31:0]               imem_data,
  input  logic                      dmem_valid,
  input  logic [31:0]               dmem_addr,
  input  logic [3:0]                dmem_wstrb,
  input  logic [31:0]               dmem_wdata,
  output logic [31:0]               dmem_rdata,
  output logic                      stall,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_wstrb,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic                      out_valid,
  output logic [31:0]               out_data,
  output logic                      err_valid,
  output logic [31:0]               err_addr,
  output logic [31:0]               stall_count
);

  localparam int unsigned WordShift = MEM_ADDR_WIDTH + 2;

  // StFirst: start of a request set. StFetch: the data access is done and
  // only the fetch remains.
  typedef enum logic [0:0] {StFirst, StFetch} state_e;

  state_e      state_q, state_d;
  logic [31:0] imem_data_q, imem_data_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic                      i_ok, d_mem, d_out, d_bad;
  logic                      fetch_phase, fetch_done;
  logic [MEM_ADDR_WIDTH-1:0] i_word, d_word;
  logic [31:0]               out_merge;

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> WordShift) == 32'd0;
  endfunction

  // Request decode
  always_comb begin
    i_ok      = in_range(imem_addr);
    d_mem     = dmem_valid && in_range(dmem_addr);
    d_out     = dmem_valid && !d_mem && (dmem_addr == OUT_ADDR);
    d_bad     = dmem_valid && !d_mem && !d_out;
    i_word    = imem_addr[MEM_ADDR_WIDTH+1:2];
    d_word    = dmem_addr[MEM_ADDR_WIDTH+1:2];
    out_merge = '0;
    for (int b = 0; b < 4; b++) begin
      out_merge[8*b +: 8] = dmem_wstrb[b] ? dmem_wdata[8*b +: 8] : 8'h00;
    end
  end

  // Sequencing, memory request and next-state
  always_comb begin
    state_d      = state_q;
    imem_data_d  = imem_data_q;
    dmem_rdata_d = dmem_rdata_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    err_valid_d  = 1'b0;
    err_addr_d   = err_addr_q;
    mem_valid    = 1'b0;
    mem_addr     = i_word;
    mem_wstrb    = 4'h0;
    mem_wdata    = 32'h0;
    stall        = 1'b1;
    fetch_phase  = 1'b0;
    fetch_done   = 1'b0;

    if (!reset) begin
      case (state_q)
        StFirst: begin
          if (d_mem) begin
            // Data access first; the fetch follows in StFetch, so a store is
            // issued exactly once and never repeated while the fetch waits.
            mem_valid = 1'b1;
            mem_addr  = d_word;
            mem_wstrb = dmem_wstrb;
            mem_wdata = dmem_wdata;
            if (mem_ready) begin
              dmem_rdata_d = mem_rdata;
              state_d      = StFetch;
            end
          end else begin
            fetch_phase = 1'b1;
          end
        end
        StFetch: fetch_phase = 1'b1;
        default: state_d = StFirst;
      endcase

      if (fetch_phase) begin
        if (i_ok) begin
          mem_valid = 1'b1;
          mem_addr  = i_word;
          // Release the core in the handshake cycle itself.
          stall     = !mem_ready;
          if (mem_ready) begin
            imem_data_d = mem_rdata;
            fetch_done  = 1'b1;
          end
        end else begin
          stall       = 1'b0;
          imem_data_d = 32'h0;
          fetch_done  = 1'b1;
        end
      end

      if (fetch_done) begin
        state_d = StFirst;
        if (!i_ok) begin
          err_valid_d = 1'b1;
          err_addr_d  = imem_addr;
        end
        // Non-memory data side effects happen only when the set completes so
        // that a fetch wait cannot repeat them.
        if (state_q == StFirst) begin
          if (d_out) begin
            dmem_rdata_d = 32'h0;
            if (dmem_wstrb != 4'h0) begin
              out_valid_d = 1'b1;
              out_data_d  = out_merge;
            end
          end
          if (d_bad) begin
            // A data error wins over a fetch error in the same set.
            dmem_rdata_d = 32'h0;
            err_valid_d  = 1'b1;
            err_addr_d   = dmem_addr;
          end
        end
      end
    end

    stall_count_d = (stall && (stall_count_q != 32'hFFFF_FFFF)) ?
                    stall_count_q + 32'd1 : stall_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StFirst;
      imem_data_q   <= 32'h0;
      dmem_rdata_q  <= 32'h0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'h0;
      err_valid_q   <= 1'b0;
      err_addr_q    <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      imem_data_q   <= imem_data_d;
      dmem_rdata_q  <= dmem_rdata_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      err_valid_q   <= err_valid_d;
      err_addr_q    <= err_addr_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign imem_data   = imem_data_q;
  assign dmem_rdata  = dmem_rdata_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign err_valid   = err_valid_q;
  assign err_addr    = err_addr_q;
  assign stall_count = stall_count_q;

endmodule
